// File: rtl/io_bridge_pkg.sv
// Shared I/O map constants for the core memory bridge.
// Holds MMIO addresses, the I/O segment tag and status bit indices.
package io_defs;

  localparam logic [31:0] IO_RX_TX_ADDR  = 32'h0003_0000;
  localparam logic [31:0] IO_STATUS_ADDR = 32'h0003_0004;
  localparam logic [1:0]  IO_SEG         = 2'b11;

  localparam int TXRDY = 0;
  localparam int RXV   = 1;
  localparam int OVF   = 2;

endpackage

// File: rtl/io_bridge_if.sv
// Byte-wide core memory port: address, write data, write enable, read data, ready.
// master = CPU core side, slave = bridge side.
interface io_bridge_if;

  logic [31:0] core_addr;
  logic [7:0]  core_dout;
  logic        core_wr;
  logic [7:0]  core_din;
  logic        core_rdy;

  modport master (
    output core_addr, core_dout, core_wr,
    input  core_din, core_rdy
  );

  modport slave (
    input  core_addr, core_dout, core_wr,
    output core_din, core_rdy
  );

endinterface

// File: rtl/io_bridge_sync_fifo.sv
// Circular-buffer synchronous FIFO with occupancy count.
// Ports: push/din in, pop/dout out, full, empty, count; async active-low rst.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Core memory-port bridge: RAM/MMIO decode, TX FIFO, RX read, halt flag.
// Ports: core bus (slave), RAM port, UART tx/rx, halt; async active-low rst.
module io_bridge
  import io_defs::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  io_bridge_if.slave        bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              halt
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          is_io;
  logic          hit_rxtx;
  logic          hit_stat;
  logic          tx_wr;
  logic          halt_wr;
  logic          push;
  logic          pop;
  logic          tx_full;
  logic          tx_empty;
  logic          ovf;
  logic          sel_io_q;
  logic [7:0]    status;
  logic [7:0]    io_rdata;
  logic [7:0]    io_rdata_q;
  logic [CW-1:0] tx_count;
  wire           unused_ok = &{1'b0, tx_count};

  assign is_io    = bus.core_addr[17:16] == IO_SEG;
  assign hit_rxtx = is_io && (bus.core_addr == IO_RX_TX_ADDR);
  assign hit_stat = is_io && (bus.core_addr == IO_STATUS_ADDR);
  assign tx_wr    = bus.core_wr & hit_rxtx;
  assign halt_wr  = bus.core_wr & hit_stat;

  assign push     = tx_wr & rdy_in & ~tx_full;
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~tx_empty;

  assign ram_addr  = bus.core_addr[RAM_AW-1:0];
  assign ram_wdata = bus.core_dout;
  assign ram_we    = bus.core_wr & ~is_io & rdy_in;

  assign rx_pop = ~bus.core_wr & hit_rxtx & rx_valid & rdy_in;

  assign bus.core_rdy = rdy_in & ~tx_full;
  assign bus.core_din = sel_io_q ? io_rdata_q : ram_rdata;

  always_comb begin
    status        = '0;
    status[TXRDY] = ~tx_full;
    status[RXV]   = rx_valid;
    status[OVF]   = ovf;
  end

  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      hit_rxtx: io_rdata = rx_valid ? rx_data : 8'h00;
      hit_stat: io_rdata = status;
      default:  io_rdata = '0;
    endcase
  end

  // Read registers give I/O the same one-cycle latency as the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
      ovf        <= 1'b0;
      halt       <= 1'b0;
    end else if (rdy_in) begin
      sel_io_q   <= is_io;
      io_rdata_q <= io_rdata;
      if (tx_wr && tx_full) ovf  <= 1'b1;
      if (halt_wr)          halt <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.core_dout),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge with RAM model and scoreboards.
// Read and TX results are queued at stimulus time and compared on output.
module tb_io_bridge;
  import io_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halt;

  io_bridge_if bus ();

  io_bridge #(.RAM_AW(17), .TX_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_in    (rdy_in),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_pop    (rx_pop),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [0:131071];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rd_q [$];
  logic s_we, s_pop, s_rdy, s_val;

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (rx_pop) pop_cnt++;
  end

  // TX scoreboard: a byte leaves on every edge with tx_valid & tx_ready.
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      n_vec++;
      if (tx_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_extra: got %02h, required none", tx_data);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (tx_data !== e) begin
          n_err++;
          $display("FAIL tx_data: got %02h, required %02h", tx_data, e);
        end
      end
    end
  end

  task automatic bus_op(input logic [31:0] a, input logic w,
                        input logic [7:0] d);
    bus.core_addr = a;
    bus.core_wr   = w;
    bus.core_dout = d;
    @(negedge clk);
    s_we  = ram_we;
    s_pop = rx_pop;
    s_rdy = bus.core_rdy;
    s_val = tx_valid;
    @(posedge clk);
    #1;
    bus.core_wr   = 1'b0;
    bus.core_addr = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e,
                    input string nm);
    logic [7:0] x;
    rd_q.push_back(e);
    bus_op(a, 1'b0, 8'h00);
    x = rd_q.pop_front();
    n_vec++;
    if (bus.core_din !== x) begin
      n_err++;
      $display("FAIL %s: got %02h, required %02h", nm, bus.core_din, x);
    end
  endtask

  task automatic tx_wr(input logic [7:0] d, input logic accept);
    if (accept) tx_q.push_back(d);
    bus_op(IO_RX_TX_ADDR, 1'b1, d);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (tx_q.size() == 0 && !tx_valid) break;
      idle(1);
    end
    n_vec++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s: left %0d tx_valid %b, required 0 0",
               nm, tx_q.size(), tx_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (bus.core_rdy !== 1'b1 || tx_valid !== 1'b0 ||
        halt !== 1'b0 || rx_pop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: rdy %b txv %b halt %b pop %b, required 1000",
               bus.core_rdy, tx_valid, halt, rx_pop);
    end
    idle(2);
    n_vec++;
    if (bus.core_din !== 8'h00) begin
      n_err++;
      $display("FAIL reset_din: got %02h, required 00", bus.core_din);
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_ram();
    int w0;
    w0 = we_cnt;
    bus_op(32'h0000_0123, 1'b1, 8'hA5);
    rd(32'h0000_0123, 8'hA5, "ram_rd");
    n_vec++;
    if (we_cnt - w0 != 1) begin
      n_err++;
      $display("FAIL ram_we_pulses: got %0d, required 1", we_cnt - w0);
    end
    bus_op(32'h0001_FFFF, 1'b1, 8'h3C);
    rd(32'h0001_FFFF, 8'h3C, "ram_top");
  endtask

  task automatic test_tx_order();
    tx_ready = 1'b1;
    tx_wr(8'h41, 1'b1);
    tx_wr(8'h42, 1'b1);
    tx_wr(8'h43, 1'b1);
    wait_drain("tx_order");
  endtask

  task automatic test_rx_status();
    int p0;
    p0 = pop_cnt;
    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    rd(IO_STATUS_ADDR, 8'h03, "status_rx");
    rd(IO_RX_TX_ADDR, 8'h7E, "rx_data");
    n_vec++;
    if (s_pop !== 1'b1 || pop_cnt - p0 != 1) begin
      n_err++;
      $display("FAIL rx_pop: pulses %0d, required 1", pop_cnt - p0);
    end
    rx_valid = 1'b0;
    rd(IO_RX_TX_ADDR, 8'h00, "rx_empty");
    rd(32'h0003_0008, 8'h00, "io_other");
  endtask

  task automatic test_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_wr(8'h10 + 8'(i), 1'b1);
    tx_ready = 1'b1;
    for (int i = 3; i < 13; i++) tx_wr(8'h10 + 8'(i), 1'b1);
    tx_ready = 1'b0;
    for (int i = 13; i < 17; i++) tx_wr(8'h10 + 8'(i), 1'b1);
    tx_wr(8'h21, 1'b1);
    n_vec++;
    if (s_rdy !== 1'b1 || bus.core_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL pp_count: rdy %b->%b, required 1->0",
               s_rdy, bus.core_rdy);
    end
    tx_ready = 1'b1;
    wait_drain("pp_drain");
  endtask

  task automatic test_tx_full();
    tx_ready = 1'b0;
    tx_wr(8'h80, 1'b1);
    n_vec++;
    if (s_val !== 1'b0 || tx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL no_bypass: txv %b->%b, required 0->1", s_val, tx_valid);
    end
    for (int i = 1; i < 8; i++) tx_wr(8'h80 + 8'(i), 1'b1);
    n_vec++;
    if (s_rdy !== 1'b1 || bus.core_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL full_rdy: rdy %b->%b, required 1->0",
               s_rdy, bus.core_rdy);
    end
    tx_wr(8'hEE, 1'b0);
    rd(IO_STATUS_ADDR, 8'h04, "status_ovf");
    tx_ready = 1'b1;
    wait_drain("full_drain");
    n_vec++;
    if (bus.core_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rdy_back: got %b, required 1", bus.core_rdy);
    end
  endtask

  task automatic test_halt_reset();
    int w0;
    w0 = we_cnt;
    rdy_in = 1'b0;
    bus_op(IO_STATUS_ADDR, 1'b1, 8'h00);
    bus_op(32'h0000_0200, 1'b1, 8'h55);
    n_vec++;
    if (halt !== 1'b0 || s_rdy !== 1'b0 || we_cnt != w0) begin
      n_err++;
      $display("FAIL rdy_hold: halt %b rdy %b we %0d, required 0 0 0",
               halt, s_rdy, we_cnt - w0);
    end
    rdy_in = 1'b1;
    bus_op(IO_STATUS_ADDR, 1'b1, 8'h00);
    idle(3);
    n_vec++;
    if (halt !== 1'b1) begin
      n_err++;
      $display("FAIL halt_sticky: got %b, required 1", halt);
    end
    tx_ready = 1'b0;
    tx_wr(8'h01, 1'b1);
    tx_wr(8'h02, 1'b1);
    rst = 1'b0;
    #1;
    tx_q.delete();
    n_vec++;
    if (halt !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: halt %b txv %b, required 0 0",
               halt, tx_valid);
    end
    idle(1);
    rst = 1'b1;
    tx_ready = 1'b1;
    idle(3);
    n_vec++;
    if (tx_valid !== 1'b0 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst: txv %b halt %b, required 0 0",
               tx_valid, halt);
    end
    rd(IO_STATUS_ADDR, 8'h01, "status_rst");
  endtask

  initial begin
    rst           = 1'b0;
    rdy_in        = 1'b1;
    tx_ready      = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    bus.core_addr = 32'h0;
    bus.core_wr   = 1'b0;
    bus.core_dout = 8'h00;
    test_reset();
    test_ram();
    test_tx_order();
    test_rx_status();
    test_push_pop();
    test_tx_full();
    test_halt_reset();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
